// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one multiplier bit per clock.
// Optional signed (two's complement) operation is built when SEQ_MUL_SIGNED_EN is defined.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
`ifdef SEQ_MUL_SIGNED_EN
  input  logic               signed_op_i,
`endif
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     product_q, product_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     acc_step, result;
  logic [WIDTH-1:0]  a_mag, b_mag;

`ifdef SEQ_MUL_SIGNED_EN
  logic neg_q, neg_d, neg_cap;

  // Most negative input negates to itself, which read unsigned is 2**(WIDTH-1).
  always_comb begin
    a_mag   = (signed_op_i && a_i[WIDTH-1]) ? -a_i : a_i;
    b_mag   = (signed_op_i && b_i[WIDTH-1]) ? -b_i : b_i;
    neg_cap = signed_op_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
  end

  assign result = neg_q ? -acc_step : acc_step;
`else
  assign a_mag  = a_i;
  assign b_mag  = b_i;
  assign result = acc_step;
`endif

  assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
`ifdef SEQ_MUL_SIGNED_EN
    neg_d     = neg_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = '0;
`ifdef SEQ_MUL_SIGNED_EN
          neg_d    = neg_cap;
`endif
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          product_d = result;
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
`ifdef SEQ_MUL_SIGNED_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
`ifdef SEQ_MUL_SIGNED_EN
      neg_q     <= neg_d;
`endif
    end
  end

  assign busy_o    = (state_q == S_RUN);
  assign done_o    = (state_q == S_DONE);
  assign product_o = product_q;

endmodule
